operand_loader: RTL and testbench
=================================

OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream byte valid.
REQ-005 SHALL have port in_data  input  WIDTH  operand word; first word is A, second is B.
REQ-006 SHALL have port in_ready  output  1  loader can accept a word.
REQ-007 SHALL have port flush  input  1  abort current pair and return to LOAD_A.
REQ-008 SHALL have port out_valid  output  1  operand pair A/B presented to the ALU units (xor/and/add stages).
REQ-009 SHALL have port out_ready  input  1  downstream has consumed the pair.
REQ-010 SHALL have ports out_a, out_b  output  WIDTH each  registered operands.
REQ-011 SHALL have port pair_cnt  output  8  count of completed output handshakes.

Function
REQ-012 SHALL implement FSM states LOAD_A, LOAD_B, PRESENT.
REQ-013 in_ready SHALL be 1 in LOAD_A and LOAD_B, 0 in PRESENT, and 0 while rst is high.
REQ-014 Word accepted when in_valid and in_ready are both high at a clock edge.
REQ-015 LOAD_A + accept: out_a <= in_data, go to LOAD_B.
REQ-016 LOAD_B + accept: out_b <= in_data, go to PRESENT; out_valid is high from the next cycle (1-cycle latency after B).
REQ-017 PRESENT: out_valid = 1, out_a/out_b held stable until out_valid and out_ready are both high.
REQ-018 PRESENT + out_ready: out_valid drops next cycle, pair_cnt increments, go to LOAD_A.
REQ-019 Maximum throughput SHALL be one pair per 3 cycles; there is no overlap of loading and presenting.
REQ-020 pair_cnt SHALL wrap from 255 to 0 with no flag.
REQ-021 flush SHALL take priority over all other events: next state LOAD_A, out_valid 0, out_a/out_b keep their values, pair_cnt unchanged. This holds even if out_ready is high in the same cycle.
REQ-022 out_ready SHALL be ignored outside PRESENT, and in_valid SHALL be ignored in PRESENT.

Reset
REQ-023 On rst: state LOAD_A, out_valid 0, out_a 0, out_b 0, pair_cnt 0, in_ready 0.
REQ-024 rst asserted mid-pair (LOAD_B or PRESENT) SHALL discard the partial or presented pair with no handshake counted.

Configuration
REQ-025 Macro OPERAND_LOADER_PARITY_EN: when defined, the following ports SHALL be added:
- in_parity (input, 1): even parity over in_data.
- par_err (output, 1).
REQ-026 With OPERAND_LOADER_PARITY_EN, an accepted word with a parity mismatch SHALL be dropped: state and operands are unchanged, and par_err pulses high for 1 cycle. par_err resets to 0.
REQ-027 Without the macro, these ports SHALL be absent and every accepted word SHALL be loaded.

Structure
REQ-028 Package operand_loader_pkg SHALL hold:
- the FSM state enum (LOAD_A, LOAD_B, PRESENT);
- the default WIDTH constant;
- the pair_cnt width constant (8).
REQ-029 Sub-module operand_loader_parity SHALL hold the combinational parity check, instantiated only under OPERAND_LOADER_PARITY_EN; all other logic is flat in operand_loader.

Verification
REQ-030 Basic load: rst 2 cycles, then A=0x3C, B=0xA5, out_ready=1 -> out_valid 1 cycle after B, out_a=0x3C, out_b=0xA5 (downstream XOR = 0x99), pair_cnt=1.
REQ-031 Backpressure: out_ready=0 for 5 cycles in PRESENT -> out_valid held high, operands stable, in_ready=0; release -> pair_cnt increments exactly once.
REQ-032 Flush: flush after A=0xFF in LOAD_B -> next word 0x01 loads as A; flush with out_ready=1 in PRESENT -> pair_cnt unchanged.
REQ-033 Wrap: 256 consecutive pairs -> pair_cnt returns to 0x00.
REQ-034 Mid-operation reset: rst during PRESENT -> next cycle out_valid=0, out_a=out_b=0, pair_cnt=0.
REQ-035 Parity (macro defined): A=0x03 with in_parity=1 -> word dropped, par_err 1-cycle pulse, state stays LOAD_A; then A=0x03 with in_parity=0 -> accepted.

Source files
------------

// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader.
// Optional parity checking is enabled by defining OPERAND_LOADER_PARITY_EN.
package operand_loader_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } state_e;

    function automatic logic even_par(input logic [DEF_WIDTH-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/operand_loader_parity.sv
// Combinational even-parity check on an incoming operand word.
// Only instantiated when OPERAND_LOADER_PARITY_EN is defined.
module operand_loader_parity
    import operand_loader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             parity_i,
    output logic             par_ok_o
);

    // The parity bit makes the total count of ones even.
    assign par_ok_o = ((^data_i) ^ parity_i) == 1'b0;

endmodule

// File: rtl/operand_loader.sv
// Collects two operand words A then B and presents them as one pair.
// Define OPERAND_LOADER_PARITY_EN to add in_parity/par_err word checking.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
`ifdef OPERAND_LOADER_PARITY_EN
    input  logic             in_parity,
    output logic             par_err,
`endif
    output logic [CNT_W-1:0] pair_cnt
);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               valid_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               accept;
    logic               word_ok;

`ifdef OPERAND_LOADER_PARITY_EN
    logic               par_err_q;
    logic               par_ok;

    operand_loader_parity #(
        .WIDTH(WIDTH)
    ) u_parity (
        .data_i  (in_data),
        .parity_i(in_parity),
        .par_ok_o(par_ok)
    );

    assign word_ok = par_ok;
    assign par_err = par_err_q;
`else
    assign word_ok = 1'b1;
`endif

    assign in_ready  = !rst && (state_q != PRESENT);
    assign accept    = in_valid && in_ready;
    assign cnt_d     = cnt_q + 1'b1;

    assign out_valid = valid_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign pair_cnt  = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
`ifdef OPERAND_LOADER_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
`ifdef OPERAND_LOADER_PARITY_EN
            par_err_q <= 1'b0;
`endif
            // Flush wins over loading and over a same-cycle handshake.
            if (flush) begin
                state_q <= LOAD_A;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    LOAD_A: begin
                        if (accept && word_ok) begin
                            a_q     <= in_data;
                            state_q <= LOAD_B;
                        end
`ifdef OPERAND_LOADER_PARITY_EN
                        if (accept && !word_ok)
                            par_err_q <= 1'b1;
`endif
                    end
                    LOAD_B: begin
                        if (accept && word_ok) begin
                            b_q     <= in_data;
                            valid_q <= 1'b1;
                            state_q <= PRESENT;
                        end
`ifdef OPERAND_LOADER_PARITY_EN
                        if (accept && !word_ok)
                            par_err_q <= 1'b1;
`endif
                    end
                    PRESENT: begin
                        if (out_ready) begin
                            valid_q <= 1'b0;
                            cnt_q   <= cnt_d;
                            state_q <= LOAD_A;
                        end
                    end
                    default: begin
                        state_q <= LOAD_A;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader.
// Parity scenario runs when OPERAND_LOADER_PARITY_EN is defined.
module tb_operand_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic [7:0] pair_cnt;

    int total = 0;
    int bad   = 0;

`ifdef OPERAND_LOADER_PARITY_EN
    logic in_parity;
    logic par_err;
    logic par_bad = 1'b0;
    assign in_parity = (^in_data) ^ par_bad;
`endif

    always #5 clk = ~clk;

    operand_loader #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_a    (out_a),
        .out_b    (out_b),
`ifdef OPERAND_LOADER_PARITY_EN
        .in_parity(in_parity),
        .par_err  (par_err),
`endif
        .pair_cnt (pair_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        in_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        flush = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        total++;
        if ({in_ready, out_valid, out_a, out_b, pair_cnt} !== 27'd0) begin
            bad++;
            $display("FAIL reset: rdy=%b vld=%b a=%h b=%h cnt=%h want all 0",
                     in_ready, out_valid, out_a, out_b, pair_cnt);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h3C;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_a !== 8'h3C) begin
            bad++;
            $display("FAIL basic_a: vld=%b a=%h want 0 3c", out_valid, out_a);
        end
        in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_a !== 8'h3C || out_b !== 8'hA5
            || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_present: vld=%b a=%h b=%h rdy=%b want 1 3c a5 0",
                     out_valid, out_a, out_b, in_ready);
        end
        total++;
        if ((out_a ^ out_b) !== 8'h99) begin
            bad++;
            $display("FAIL basic_xor: got %h want 99", out_a ^ out_b);
        end
        tick();
        total++;
        if (out_valid !== 1'b0 || pair_cnt !== 8'd1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_done: vld=%b cnt=%0d rdy=%b want 0 1 1",
                     out_valid, pair_cnt, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1;
        in_data = 8'h11;
        tick();
        in_data = 8'h22;
        tick();
        // Words offered while presenting must be ignored.
        in_data = 8'h77;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_a !== 8'h11 || out_b !== 8'h22
                || in_ready !== 1'b0 || pair_cnt !== 8'd1) begin
                bad++;
                $display("FAIL backpressure_hold[%0d]: vld=%b a=%h b=%h rdy=%b cnt=%0d",
                         i, out_valid, out_a, out_b, in_ready, pair_cnt);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || pair_cnt !== 8'd2) begin
            bad++;
            $display("FAIL backpressure_release: vld=%b cnt=%0d want 0 2",
                     out_valid, pair_cnt);
        end
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        total++;
        if (pair_cnt !== 8'd2 || out_a !== 8'h11) begin
            bad++;
            $display("FAIL backpressure_once: cnt=%0d a=%h want 2 11",
                     pair_cnt, out_a);
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1;
        in_data = 8'hFF;
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h01;
        tick();
        in_data = 8'h02;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_a !== 8'h01 || out_b !== 8'h02) begin
            bad++;
            $display("FAIL flush_loadb: vld=%b a=%h b=%h want 1 01 02",
                     out_valid, out_a, out_b);
        end
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || pair_cnt !== 8'd2 || in_ready !== 1'b1
            || out_a !== 8'h01 || out_b !== 8'h02) begin
            bad++;
            $display("FAIL flush_present: vld=%b cnt=%0d rdy=%b a=%h b=%h want 0 2 1 01 02",
                     out_valid, pair_cnt, in_ready, out_a, out_b);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int p = 0; p < 256; p++) begin
            in_data = p[7:0];
            tick();
            in_data = ~p[7:0];
            tick();
            tick();
            if (p == 254) begin
                total++;
                if (pair_cnt !== 8'd255) begin
                    bad++;
                    $display("FAIL wrap_255: got %0d want 255", pair_cnt);
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++;
        if (pair_cnt !== 8'd0 || out_a !== 8'hFF || out_b !== 8'h00) begin
            bad++;
            $display("FAIL wrap_zero: cnt=%0d a=%h b=%h want 0 ff 00",
                     pair_cnt, out_a, out_b);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h5A;
        tick();
        in_data = 8'h6B;
        tick();
        tick();
        out_ready = 1'b0;
        in_data = 8'h12;
        tick();
        in_data = 8'h34;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || pair_cnt !== 8'd1) begin
            bad++;
            $display("FAIL midrst_setup: vld=%b cnt=%0d want 1 1",
                     out_valid, pair_cnt);
        end
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_a !== 8'h00 || out_b !== 8'h00
            || pair_cnt !== 8'd0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst: vld=%b a=%h b=%h cnt=%0d rdy=%b want 0 00 00 0 0",
                     out_valid, out_a, out_b, pair_cnt, in_ready);
        end
        rst = 1'b0;
        out_ready = 1'b0;
        tick();
        total++;
        if (pair_cnt !== 8'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_after: cnt=%0d rdy=%b want 0 1",
                     pair_cnt, in_ready);
        end
    endtask

`ifdef OPERAND_LOADER_PARITY_EN
    task automatic test_parity();
        do_reset();
        in_valid = 1'b1;
        in_data = 8'h03;
        par_bad = 1'b1;
        tick();
        in_valid = 1'b0;
        par_bad = 1'b0;
        total++;
        if (par_err !== 1'b1 || out_a !== 8'h00 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL parity_drop: err=%b a=%h rdy=%b want 1 00 1",
                     par_err, out_a, in_ready);
        end
        tick();
        total++;
        if (par_err !== 1'b0) begin
            bad++;
            $display("FAIL parity_pulse: err=%b want 0", par_err);
        end
        in_valid = 1'b1;
        in_data = 8'h03;
        tick();
        total++;
        if (out_a !== 8'h03 || par_err !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL parity_accept: a=%h err=%b vld=%b want 03 0 0",
                     out_a, par_err, out_valid);
        end
        in_data = 8'h04;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_b !== 8'h04) begin
            bad++;
            $display("FAIL parity_pair: vld=%b b=%h want 1 04",
                     out_valid, out_b);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_wrap();
        test_mid_reset();
`ifdef OPERAND_LOADER_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
